// File: rtl/ram_access_ctrl_pkg.sv
// Shared definitions for the simple_ram request sequencer: state encodings and default widths.
package ram_access_ctrl_pkg;

  localparam int BYTE_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD_A = 3'd2,
    ST_RD_D = 3'd3,
    ST_RSP  = 3'd4
  } state_t;

endpackage

// File: rtl/ram_access_ctrl_ts_buf.sv
// Tri-state driver for the shared RAM data bus; releases the bus whenever en is low.
module ram_access_ctrl_ts_buf #(
  parameter int W = 8
) (
  input  logic         en,
  input  logic [W-1:0] data,
  inout  wire  [W-1:0] bus
);

  assign bus = en ? data : {W{1'bz}};

endmodule

// File: rtl/ram_access_ctrl.sv
// Single-outstanding request sequencer in front of simple_ram: valid/ready request in,
// registered RAM strobes out, read data returned on a valid/ready response channel.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BYTE_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [BYTE_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] address,
  output logic              r_e,
  output logic              w_e,
  inout  wire  [BYTE_W-1:0] mem_bus
);

  state_t            state, state_nxt;
  logic [BYTE_W-1:0] wdata, wdata_nxt, rdata_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              r_e_nxt, w_e_nxt, rsp_valid_nxt, accept;

  // req_ready is only ever high in IDLE, so this also qualifies the state.
  assign accept = req_valid && req_ready;

  always_comb begin
    state_nxt     = state;
    addr_nxt      = address;
    wdata_nxt     = wdata;
    rdata_nxt     = rsp_rdata;
    rsp_valid_nxt = rsp_valid;
    r_e_nxt       = 1'b0;
    w_e_nxt       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          addr_nxt  = req_addr;
          wdata_nxt = req_wdata;
          if (req_write) begin
            state_nxt = ST_WR;
            w_e_nxt   = 1'b1;
          end else begin
            state_nxt = ST_RD_A;
            r_e_nxt   = 1'b1;
          end
        end
      end
      ST_WR:   state_nxt = ST_IDLE;
      ST_RD_A: begin
        // Hold r_e through RD_D so the RAM keeps driving the bus while we sample it.
        state_nxt = ST_RD_D;
        r_e_nxt   = 1'b1;
      end
      ST_RD_D: begin
        state_nxt     = ST_RSP;
        rdata_nxt     = mem_bus;
        rsp_valid_nxt = 1'b1;
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_nxt     = ST_IDLE;
          rsp_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      address   <= '0;
      r_e       <= 1'b0;
      w_e       <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_ready <= (state_nxt == ST_IDLE);
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rdata_nxt;
      address   <= addr_nxt;
      r_e       <= r_e_nxt;
      w_e       <= w_e_nxt;
    end
  end

  always_ff @(posedge clk) begin
    wdata <= wdata_nxt;
  end

  ram_access_ctrl_ts_buf #(
    .W (BYTE_W)
  ) u_bus_drv (
    .en   (w_e),
    .data (wdata),
    .bus  (mem_bus)
  );

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl against a behavioural simple_ram with a read-data scoreboard.
module tb_ram_access_ctrl;

  logic       clk = 1'b0;
  logic       rst, req_valid, req_write, rsp_ready;
  logic [7:0] req_addr, req_wdata;
  logic       req_ready, rsp_valid, r_e, w_e;
  logic [7:0] rsp_rdata, address;
  wire  [7:0] mem_bus;

  int tests = 0;
  int fails = 0;

  logic [7:0] ram_mem [256];
  logic [7:0] ram_rd;
  logic [7:0] model   [256];
  logic [7:0] exp_q   [$];

  always #5 clk = ~clk;

  ram_access_ctrl #(.BYTE_W(8), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .address   (address),
    .r_e       (r_e),
    .w_e       (w_e),
    .mem_bus   (mem_bus)
  );

  // simple_ram: registered read, drives the bus while r_e is high.
  assign mem_bus = r_e ? ram_rd : 8'bz;
  always @(posedge clk) begin
    if (w_e) ram_mem[address] <= mem_bus;
    if (r_e) ram_rd <= ram_mem[address];
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      tests++;
      assert (!(r_e === 1'b1 && w_e === 1'b1)) else begin
        fails++;
        $error("FAIL enable_overlap observed r_e=%0b w_e=%0b expected not both 1", r_e, w_e);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (wr) model[a] = d;
    else    exp_q.push_back(model[a]);
  endtask

  task automatic get_rsp(input string tag);
    int n = 0;
    logic [7:0] e;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(rsp_rdata), 32'(e));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'h00;
      model[i]   = 8'h00;
    end
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b0;
    req_addr = 8'h00; req_wdata = 8'h00;

    // Reset held for two edges
    repeat (2) @(negedge clk);
    check("rst_r_e", 32'(r_e), 32'd0);
    check("rst_w_e", 32'(w_e), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Write then read with exact latency
    issue(1'b1, 8'h10, 8'hA5);
    issue(1'b0, 8'h10, 8'h00);
    @(negedge clk);
    check("lat_edge1_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("lat_edge2_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("lat_edge3_valid", 32'(rsp_valid), 32'd1);
    check("lat_rdata", 32'(rsp_rdata), 32'hA5);
    get_rsp("rd_10");

    // Response stall with a request presented outside IDLE
    issue(1'b0, 8'h10, 8'h00);
    repeat (3) @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20; req_wdata = 8'h77;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_rdata", 32'(rsp_rdata), 32'hA5);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_address", 32'(address), 32'h10);
      @(negedge clk);
    end
    req_valid = 1'b0;
    get_rsp("stall_rsp");
    @(negedge clk);
    check("release_valid", 32'(rsp_valid), 32'd0);
    check("release_req_ready", 32'(req_ready), 32'd1);
    check("ignored_write", 32'(ram_mem[8'h20]), 32'(model[8'h20]));

    // Read followed immediately by a write
    issue(1'b1, 8'hFF, 8'h5A);
    issue(1'b0, 8'hFF, 8'h00);
    get_rsp("rd_ff");
    issue(1'b1, 8'h00, 8'hC3);
    @(negedge clk);
    check("wr_w_e", 32'(w_e), 32'd1);
    check("wr_r_e", 32'(r_e), 32'd0);
    check("wr_bus_known", 32'($isunknown(mem_bus)), 32'd0);
    check("wr_bus_data", 32'(mem_bus), 32'hC3);
    @(negedge clk);
    check("ram_00", 32'(ram_mem[8'h00]), 32'hC3);
    issue(1'b0, 8'h00, 8'h00);
    get_rsp("rd_00");

    // Reset while in RD_D aborts the read
    issue(1'b0, 8'h10, 8'h00);
    repeat (2) @(negedge clk);
    check("rdd_r_e", 32'(r_e), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_valid", 32'(rsp_valid), 32'd0);
      check("abort_r_e", 32'(r_e), 32'd0);
    end
    issue(1'b0, 8'h10, 8'h00);
    get_rsp("rd_after_abort");

    // Full address sweep
    for (int a = 0; a < 256; a++) issue(1'b1, 8'(a), 8'(a) ^ 8'h3C);
    for (int a = 0; a < 256; a++) begin
      issue(1'b0, 8'(a), 8'h00);
      get_rsp("sweep");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
